// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - UART program loader that fills instruction memory, then releases the core

module uart_boot_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_tdata,
    output logic       rx_tvalid,
    output logic       rx_frame_err
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t        rx_state;
    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       rx_shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta      <= 1'b1;
            rx_sync      <= 1'b1;
            rx_prev      <= 1'b1;
            rx_state     <= RX_IDLE;
            bit_cnt      <= '0;
            bit_idx      <= '0;
            rx_shift     <= '0;
            rx_tdata     <= '0;
            rx_tvalid    <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_meta      <= rx;
            rx_sync      <= rx_meta;
            rx_prev      <= rx_sync;
            rx_tvalid    <= 1'b0;
            rx_frame_err <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_state <= RX_START;
                        bit_cnt  <= '0;
                    end
                end
                RX_START: begin
                    // a line that is high again at mid-start was only a glitch
                    if (bit_cnt == HALF_LAST) begin
                        bit_cnt  <= '0;
                        bit_idx  <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt  <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt  <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_sync) begin
                            rx_tvalid <= 1'b1;
                            rx_tdata  <= rx_shift;
                        end else begin
                            rx_frame_err <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end
endmodule

module uart_boot_loader #(
    parameter int CLKS_PER_BIT   = 434,
    parameter int ADDR_W         = 10,
    parameter int IMEM_DEPTH     = 1024,
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              UART_RX,
    output logic              IMEM_W_En,
    output logic [ADDR_W-1:0] IMEM_W_Addr,
    output logic [31:0]       IMEM_W_Data,
    output logic              Core_RST,
    output logic              Boot_Done,
    output logic              Boot_Err
);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]       DEPTH     = 17'(IMEM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_DEPTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_CNT0, S_CNT1, S_DATA, S_CHKS, S_DONE, S_ERROR} state_t;

    state_t          state;
    logic [7:0]      rx_tdata;
    logic            rx_tvalid;
    logic            rx_frame_err;
    logic [7:0]      cnt_lo;
    logic [15:0]     words_left;
    logic [1:0]      byte_idx;
    logic [7:0]      chk;
    logic [TO_W-1:0] to_cnt;
    logic [15:0]     cnt_full;
    logic            loading;
    logic            go_err;
    logic            go_done;

    uart_boot_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk          (CLK),
        .rst          (RST),
        .rx           (UART_RX),
        .rx_tdata     (rx_tdata),
        .rx_tvalid    (rx_tvalid),
        .rx_frame_err (rx_frame_err)
    );

    // a byte arriving on the last idle cycle beats the timeout
    always_comb begin
        cnt_full = {rx_tdata, cnt_lo};
        loading  = (state == S_CNT0) || (state == S_CNT1) || (state == S_DATA) || (state == S_CHKS);
        go_err   = 1'b0;
        go_done  = 1'b0;
        if (loading) begin
            if (rx_frame_err) begin
                go_err = 1'b1;
            end else if (rx_tvalid) begin
                if (state == S_CNT1 && {1'b0, cnt_full} > DEPTH) begin
                    go_err = 1'b1;
                end
                if (state == S_CHKS) begin
                    if (rx_tdata == chk) begin
                        go_done = 1'b1;
                    end else begin
                        go_err = 1'b1;
                    end
                end
            end else if (to_cnt == TO_LAST) begin
                go_err = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= S_IDLE;
            cnt_lo      <= '0;
            words_left  <= '0;
            byte_idx    <= '0;
            chk         <= '0;
            to_cnt      <= '0;
            IMEM_W_En   <= 1'b0;
            IMEM_W_Addr <= '0;
            IMEM_W_Data <= '0;
            Core_RST    <= 1'b1;
            Boot_Done   <= 1'b0;
            Boot_Err    <= 1'b0;
        end else begin
            IMEM_W_En <= 1'b0;
            if (IMEM_W_En && IMEM_W_Addr != LAST_ADDR) begin
                IMEM_W_Addr <= IMEM_W_Addr + 1'b1;
            end
            if (!loading || rx_tvalid) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (go_err) begin
                state    <= S_ERROR;
                Core_RST <= 1'b1;
                Boot_Err <= 1'b1;
            end else if (go_done) begin
                state     <= S_DONE;
                Core_RST  <= 1'b0;
                Boot_Done <= 1'b1;
            end else if (rx_tvalid) begin
                case (state)
                    S_IDLE: begin
                        if (rx_tdata == 8'hA5) begin
                            state <= S_CNT0;
                        end
                    end
                    S_CNT0: begin
                        cnt_lo <= rx_tdata;
                        chk    <= rx_tdata;
                        state  <= S_CNT1;
                    end
                    S_CNT1: begin
                        chk        <= chk ^ rx_tdata;
                        words_left <= cnt_full;
                        byte_idx   <= '0;
                        state      <= (cnt_full == 16'd0) ? S_CHKS : S_DATA;
                    end
                    S_DATA: begin
                        chk         <= chk ^ rx_tdata;
                        IMEM_W_Data <= {rx_tdata, IMEM_W_Data[31:8]};
                        byte_idx    <= byte_idx + 1'b1;
                        if (byte_idx == 2'd3) begin
                            IMEM_W_En  <= 1'b1;
                            words_left <= words_left - 1'b1;
                            if (words_left == 16'd1) begin
                                state <= S_CHKS;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb/tb_uart_boot_loader.sv - self-checking bench for uart_boot_loader

module tb_uart_boot_loader;
    localparam int CPB    = 8;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 4;
    localparam int TMO    = 300;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              UART_RX = 1'b1;
    logic              IMEM_W_En;
    logic [ADDR_W-1:0] IMEM_W_Addr;
    logic [31:0]       IMEM_W_Data;
    logic              Core_RST;
    logic              Boot_Done;
    logic              Boot_Err;

    uart_boot_loader #(
        .CLKS_PER_BIT   (CPB),
        .ADDR_W         (ADDR_W),
        .IMEM_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .UART_RX     (UART_RX),
        .IMEM_W_En   (IMEM_W_En),
        .IMEM_W_Addr (IMEM_W_Addr),
        .IMEM_W_Data (IMEM_W_Data),
        .Core_RST    (Core_RST),
        .Boot_Done   (Boot_Done),
        .Boot_Err    (Boot_Err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int           len;
        logic [191:0] bytes;
        bit           done;
        bit           err;
        int           nwr;
    } vec_t;

    vec_t        vecs[8];
    int          total = 0;
    int          bad = 0;
    logic [7:0]  tx_q[$];
    int          got_addr[$];
    logic [31:0] got_data[$];
    int          exp_addr[$];
    logic [31:0] exp_data[$];
    bit          exp_done;
    bit          exp_err;

    always @(negedge CLK) begin
        if (!RST && IMEM_W_En) begin
            got_addr.push_back(int'(IMEM_W_Addr));
            got_data.push_back(IMEM_W_Data);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation still running at time %0t, limit 3000000", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", name, got, want);
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input logic stop, input int stop_cycles);
        UART_RX = 1'b0;
        repeat (CPB) @(posedge CLK);
        #1;
        for (int i = 0; i < 8; i++) begin
            UART_RX = b[i];
            repeat (CPB) @(posedge CLK);
            #1;
        end
        UART_RX = stop;
        repeat (stop_cycles) @(posedge CLK);
        #1;
        UART_RX = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 1'b1, CPB);
    endtask

    task automatic send_q(input int max_gap);
        int g;
        for (int k = 0; k < tx_q.size(); k++) begin
            send_byte(tx_q[k]);
            g = $urandom_range(0, max_gap);
            if (g > 0) begin
                repeat (g) @(posedge CLK);
                #1;
            end
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        UART_RX = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        got_addr.delete();
        got_data.delete();
        RST = 1'b0;
    endtask

    task automatic load_vec(input logic [191:0] bv, input int len);
        tx_q.delete();
        for (int k = 0; k < len; k++) tx_q.push_back(bv[8*(len-1-k) +: 8]);
    endtask

    // Reference: parse the byte list as a frame and predict writes and final status.
    task automatic model_frame();
        int i;
        int n;
        int cnt;
        logic [7:0] x;
        exp_addr.delete();
        exp_data.delete();
        exp_done = 1'b0;
        exp_err = 1'b0;
        n = tx_q.size();
        i = 0;
        while (i < n && tx_q[i] != 8'hA5) i++;
        if (i + 2 >= n) return;
        cnt = int'(tx_q[i+1]) + 256 * int'(tx_q[i+2]);
        x = tx_q[i+1] ^ tx_q[i+2];
        i = i + 3;
        if (cnt > DEPTH) begin
            exp_err = 1'b1;
            return;
        end
        for (int w = 0; w < cnt; w++) begin
            exp_addr.push_back(w);
            exp_data.push_back({tx_q[i+3], tx_q[i+2], tx_q[i+1], tx_q[i]});
            x = x ^ tx_q[i] ^ tx_q[i+1] ^ tx_q[i+2] ^ tx_q[i+3];
            i = i + 4;
        end
        if (tx_q[i] == x) exp_done = 1'b1;
        else exp_err = 1'b1;
    endtask

    task automatic check_frame(input string tag);
        int n;
        int ea;
        repeat (4) @(posedge CLK);
        #1;
        check({tag, " done"}, Boot_Done, exp_done);
        check({tag, " err"}, Boot_Err, exp_err);
        check({tag, " core_rst"}, Core_RST, !exp_done);
        check({tag, " nwrites"}, got_addr.size(), exp_addr.size());
        n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s wr%0d addr", tag, i), got_addr[i], exp_addr[i]);
            check($sformatf("%s wr%0d data", tag, i), got_data[i], exp_data[i]);
        end
        ea = (exp_addr.size() < DEPTH) ? exp_addr.size() : DEPTH - 1;
        check({tag, " final addr"}, IMEM_W_Addr, ea);
    endtask

    initial begin
        vecs[0] = '{12, 192'hA5_02_00_13_00_00_00_93_00_10_00_92, 1'b1, 1'b0, 2};
        vecs[1] = '{12, 192'hA5_02_00_13_00_00_00_93_00_10_00_93, 1'b0, 1'b1, 2};
        vecs[2] = '{10, 192'h5A_FF_A5_01_00_EF_BE_AD_DE_23, 1'b1, 1'b0, 1};
        vecs[3] = '{3, 192'hA5_05_00, 1'b0, 1'b1, 0};
        vecs[4] = '{20, 192'hA5_04_00_01_02_03_04_05_06_07_08_09_0A_0B_0C_0D_0E_0F_10_14, 1'b1, 1'b0, 4};
        vecs[5] = '{4, 192'hA5_00_00_00, 1'b1, 1'b0, 0};
        vecs[6] = '{4, 192'hA5_00_00_01, 1'b0, 1'b1, 0};
        vecs[7] = '{3, 192'hA5_00_01, 1'b0, 1'b1, 0};

        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("reset en", IMEM_W_En, 0);
        check("reset addr", IMEM_W_Addr, 0);
        check("reset data", IMEM_W_Data, 0);
        check("reset core_rst", Core_RST, 1);
        check("reset done", Boot_Done, 0);
        check("reset err", Boot_Err, 0);

        for (int t = 0; t < 8; t++) begin
            do_reset();
            load_vec(vecs[t].bytes, vecs[t].len);
            model_frame();
            send_q(3);
            check_frame($sformatf("vec%0d", t));
            check($sformatf("vec%0d table done", t), Boot_Done, vecs[t].done);
            check($sformatf("vec%0d table err", t), Boot_Err, vecs[t].err);
            check($sformatf("vec%0d table nwrites", t), got_addr.size(), vecs[t].nwr);
        end

        // Boot_Done / Core_RST must flip exactly one cycle after the CHK strobe, then DONE absorbs.
        do_reset();
        load_vec(vecs[0].bytes, 12);
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'h00);
        tx_q.push_back(8'h12);
        model_frame();
        for (int k = 0; k < 11; k++) send_byte(tx_q[k]);
        send_bits(tx_q[11], 1'b1, CPB - 1);
        check("chk strobe cycle done", Boot_Done, 0);
        check("chk strobe cycle core_rst", Core_RST, 1);
        @(posedge CLK);
        #1;
        check("after chk done", Boot_Done, 1);
        check("after chk core_rst", Core_RST, 0);
        send_byte(8'hA5);
        send_bits(8'h00, 1'b0, CPB);
        repeat (4) @(posedge CLK);
        #1;
        send_byte(8'h12);
        check_frame("done absorbing");

        // framing error mid-DATA, then ERROR absorbs a valid frame
        do_reset();
        load_vec(192'hA5_01_00_11, 4);
        send_q(0);
        send_bits(8'h22, 1'b0, CPB);
        repeat (3) @(posedge CLK);
        #1;
        check("frame err err", Boot_Err, 1);
        check("frame err done", Boot_Done, 0);
        check("frame err core_rst", Core_RST, 1);
        check("frame err nwrites", got_addr.size(), 0);
        load_vec(192'hA5_00_00_00, 4);
        send_q(0);
        repeat (4) @(posedge CLK);
        #1;
        check("error absorbing err", Boot_Err, 1);
        check("error absorbing done", Boot_Done, 0);

        // timeout exactly TMO cycles after the last byte strobe
        do_reset();
        load_vec(192'hA5_01_00_11_22, 5);
        send_q(0);
        repeat (TMO - 1) @(posedge CLK);
        #1;
        check("timeout minus one err", Boot_Err, 0);
        @(posedge CLK);
        #1;
        check("timeout err", Boot_Err, 1);
        check("timeout core_rst", Core_RST, 1);
        check("timeout done", Boot_Done, 0);

        // reset mid-DATA restarts addressing
        do_reset();
        load_vec(192'hA5_02_00_11_22_33_44_55, 8);
        send_q(0);
        repeat (3) @(posedge CLK);
        #1;
        check("middata nwrites", got_addr.size(), 1);
        if (got_addr.size() > 0) check("middata wr0 data", got_data[0], 32'h44332211);
        check("middata addr", IMEM_W_Addr, 1);
        do_reset();
        check("rst middata addr", IMEM_W_Addr, 0);
        check("rst middata data", IMEM_W_Data, 0);
        check("rst middata core_rst", Core_RST, 1);
        load_vec(192'hA5_00_00_00, 4);
        model_frame();
        send_q(0);
        check_frame("after reset");

        // a short low glitch in CNT0 must not become a count byte
        do_reset();
        load_vec(192'hA5_00_00_00, 4);
        model_frame();
        send_byte(tx_q[0]);
        UART_RX = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        UART_RX = 1'b1;
        repeat (100) @(posedge CLK);
        #1;
        for (int k = 1; k < 4; k++) send_byte(tx_q[k]);
        check_frame("false start");

        for (int r = 0; r < 6; r++) begin
            int nj;
            int cnt;
            logic [7:0] x;
            logic [7:0] b;
            do_reset();
            tx_q.delete();
            nj = $urandom_range(0, 2);
            for (int j = 0; j < nj; j++) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hA5) b = 8'h5A;
                tx_q.push_back(b);
            end
            cnt = $urandom_range(0, DEPTH + 1);
            tx_q.push_back(8'hA5);
            tx_q.push_back(cnt[7:0]);
            tx_q.push_back(8'h00);
            x = cnt[7:0];
            for (int k = 0; k < 4 * cnt; k++) begin
                b = 8'($urandom_range(0, 255));
                tx_q.push_back(b);
                x = x ^ b;
            end
            if ($urandom_range(0, 3) == 0) x = x ^ 8'(1 << $urandom_range(0, 7));
            tx_q.push_back(x);
            model_frame();
            send_q(12);
            check_frame($sformatf("rand%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
